// File: rtl/addsub64_rr_arbiter.sv
// rtl/addsub64_rr_arbiter.sv - round-robin arbiter in front of a shared, two-stage pipelined 64-bit add/subtract datapath
module addsub64_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int WIDTH = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       sub,
    input  logic [NREQ*WIDTH-1:0] op1,
    input  logic [NREQ*WIDTH-1:0] op2,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       busy,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout
);

    localparam int BLK  = 16;
    localparam int NBLK = WIDTH / BLK;

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0]  busy_q, busy_d;
    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  rsp_clr;
    logic             grant_found;
    logic [IDW-1:0]   win_id;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic             sel_sub;

    logic [WIDTH-1:0] a1_q, b1_q;
    logic             cin1_q, v1_q;
    logic [IDW-1:0]   id1_q;

    logic             rsp_valid_q, rsp_cout_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [WIDTH-1:0] rsp_sum_q;

    logic [WIDTH-1:0] core_sum;
    logic [NBLK:0]    core_c;

    // Scan from ptr upward (wrapping) and take the first eligible requester.
    always_comb begin
        int idx;
        idx         = 0;
        eligible    = req & ~busy_q;
        grant_found = 1'b0;
        win_id      = '0;
        sel_a       = '0;
        sel_b       = '0;
        sel_sub     = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            idx = (int'(ptr_q) + j) % NREQ;
            if (!grant_found && eligible[idx]) begin
                grant_found = 1'b1;
                win_id      = idx[IDW-1:0];
                sel_a       = op1[idx*WIDTH +: WIDTH];
                sel_b       = op2[idx*WIDTH +: WIDTH];
                sel_sub     = sub[idx];
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (grant_found && !reset)
            gnt[win_id] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_found) begin
            if (int'(win_id) == NREQ - 1)
                ptr_d = '0;
            else
                ptr_d = win_id + 1'b1;
        end
    end

    // A requester stays busy through its response cycle, so it can only re-win afterwards.
    always_comb begin
        rsp_clr = '0;
        if (rsp_valid_q)
            rsp_clr[rsp_id_q] = 1'b1;
        busy_d = (busy_q & ~rsp_clr) | gnt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q  <= '0;
            busy_q <= '0;
            a1_q   <= '0;
            b1_q   <= '0;
            cin1_q <= 1'b0;
            v1_q   <= 1'b0;
            id1_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            busy_q <= busy_d;
            v1_q   <= grant_found;
            if (grant_found) begin
                a1_q   <= sel_a;
                b1_q   <= sel_sub ? ~sel_b : sel_b;
                cin1_q <= sel_sub;
                id1_q  <= win_id;
            end
        end
    end

    // Carry-select core: each block precomputes both carry-in outcomes.
    assign core_c[0] = cin1_q;
    for (genvar g = 0; g < NBLK; g++) begin : g_csel
        logic [BLK:0] s0, s1;
        assign s0 = {1'b0, a1_q[g*BLK +: BLK]} + {1'b0, b1_q[g*BLK +: BLK]};
        assign s1 = {1'b0, a1_q[g*BLK +: BLK]} + {1'b0, b1_q[g*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
        assign core_sum[g*BLK +: BLK] = core_c[g] ? s1[BLK-1:0] : s0[BLK-1:0];
        assign core_c[g+1]            = core_c[g] ? s1[BLK] : s0[BLK];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            rsp_valid_q <= v1_q;
            if (v1_q) begin
                rsp_id_q   <= id1_q;
                rsp_sum_q  <= core_sum;
                rsp_cout_q <= core_c[NBLK];
            end
        end
    end

    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_addsub64_rr_arbiter.sv
// tb/tb_addsub64_rr_arbiter.sv - directed testbench for addsub64_rr_arbiter
module tb_addsub64_rr_arbiter;

    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int WIDTH = 64;

    logic                  clock;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       sub;
    logic [NREQ*WIDTH-1:0] op1;
    logic [NREQ*WIDTH-1:0] op2;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       busy;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;

    int n_cmp;
    int n_err;

    addsub64_rr_arbiter #(.NREQ(NREQ), .IDW(IDW), .WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .sub       (sub),
        .op1       (op1),
        .op2       (op2),
        .gnt       (gnt),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        req   = '0;
        sub   = '0;
        step();
        step();
        sample();
        reset = 1'b0;
    endtask

    logic [3:0] rr_gnt [6];
    logic [3:0] blk_gnt [7];

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        req   = 4'b1111;
        sub   = '0;
        op1   = '0;
        op2   = '0;

        // Reset state, gnt forced low while reset is high
        sample();
        chk("rst_gnt",   64'(gnt), 64'h0);
        chk("rst_busy",  64'(busy), 64'h0);
        chk("rst_valid", 64'(rsp_valid), 64'h0);
        chk("rst_id",    64'(rsp_id), 64'h0);
        chk("rst_sum",   rsp_sum, 64'h0);
        chk("rst_cout",  64'(rsp_cout), 64'h0);
        reset = 1'b0;
        req   = '0;

        // Single add: all-ones + 1 wraps to 0 with carry
        step();
        req = 4'b0001;
        op1[0*WIDTH +: WIDTH] = 64'hFFFF_FFFF_FFFF_FFFF;
        op2[0*WIDTH +: WIDTH] = 64'h1;
        sample();
        chk("add_gnt_c0",  64'(gnt), 64'h1);
        chk("add_busy_c0", 64'(busy), 64'h0);
        step();
        req = '0;
        sample();
        chk("add_busy_c1",  64'(busy), 64'h1);
        chk("add_valid_c1", 64'(rsp_valid), 64'h0);
        chk("add_gnt_c1",   64'(gnt), 64'h0);
        step();
        sample();
        chk("add_valid_c2", 64'(rsp_valid), 64'h1);
        chk("add_id_c2",    64'(rsp_id), 64'h0);
        chk("add_sum_c2",   rsp_sum, 64'h0);
        chk("add_cout_c2",  64'(rsp_cout), 64'h1);
        chk("add_busy_c2",  64'(busy), 64'h1);
        step();
        sample();
        chk("add_valid_c3", 64'(rsp_valid), 64'h0);
        chk("add_busy_c3",  64'(busy), 64'h0);
        chk("add_hold_c3",  64'(rsp_cout), 64'h1);

        // Subtract with borrow, then without
        step();
        req = 4'b0100;
        sub = 4'b0100;
        op1[2*WIDTH +: WIDTH] = 64'd5;
        op2[2*WIDTH +: WIDTH] = 64'd7;
        sample();
        chk("sub1_gnt", 64'(gnt), 64'h4);
        step();
        req = '0;
        step();
        sample();
        chk("sub1_valid", 64'(rsp_valid), 64'h1);
        chk("sub1_sum",   rsp_sum, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("sub1_cout",  64'(rsp_cout), 64'h0);
        chk("sub1_id",    64'(rsp_id), 64'h2);
        step();
        req = 4'b0100;
        op1[2*WIDTH +: WIDTH] = 64'd7;
        op2[2*WIDTH +: WIDTH] = 64'd5;
        sample();
        chk("sub2_gnt", 64'(gnt), 64'h4);
        step();
        req = '0;
        step();
        sample();
        chk("sub2_valid", 64'(rsp_valid), 64'h1);
        chk("sub2_sum",   rsp_sum, 64'd2);
        chk("sub2_cout",  64'(rsp_cout), 64'h1);
        chk("sub2_id",    64'(rsp_id), 64'h2);

        // Round-robin with all requesters held high
        do_reset();
        rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        step();
        req = 4'b1111;
        sub = 4'b0000;
        for (int i = 0; i < NREQ; i++) begin
            op1[i*WIDTH +: WIDTH] = 64'(i);
            op2[i*WIDTH +: WIDTH] = 64'd100;
        end
        for (int c = 0; c < 6; c++) begin
            sample();
            chk($sformatf("rr_gnt_c%0d", c), 64'(gnt), 64'(rr_gnt[c]));
            if (c >= 2) begin
                chk($sformatf("rr_valid_c%0d", c), 64'(rsp_valid), 64'h1);
                chk($sformatf("rr_id_c%0d", c),    64'(rsp_id), 64'(c - 2));
                chk($sformatf("rr_sum_c%0d", c),   rsp_sum, 64'(98 + c));
            end
            step();
        end
        req = '0;

        // Blocking: requester 1 alone, held high
        do_reset();
        blk_gnt = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0010};
        step();
        req = 4'b0010;
        op1[1*WIDTH +: WIDTH] = 64'd10;
        op2[1*WIDTH +: WIDTH] = 64'd20;
        for (int c = 0; c < 7; c++) begin
            sample();
            chk($sformatf("blk_gnt_c%0d", c), 64'(gnt), 64'(blk_gnt[c]));
            if (c == 1 || c == 2)
                chk($sformatf("blk_busy_c%0d", c), 64'(busy), 64'h2);
            if (c == 2)
                chk("blk_sum_c2", rsp_sum, 64'd30);
            if (c < 7 - 1)
                step();
        end
        req = '0;

        // Reset during an in-flight operation
        do_reset();
        step();
        req = 4'b1000;
        op1[3*WIDTH +: WIDTH] = 64'd1;
        op2[3*WIDTH +: WIDTH] = 64'd1;
        sample();
        chk("mid_gnt_c0", 64'(gnt), 64'h8);
        step();
        reset = 1'b1;
        req   = 4'b1111;
        sample();
        chk("mid_gnt_rst",   64'(gnt), 64'h0);
        chk("mid_valid_rst", 64'(rsp_valid), 64'h0);
        step();
        sample();
        reset = 1'b0;
        req   = '0;
        chk("mid_busy_rel", 64'(busy), 64'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            sample();
            chk($sformatf("mid_novalid_%0d", c), 64'(rsp_valid), 64'h0);
        end
        step();
        req = 4'b1010;
        sample();
        chk("mid_gnt_after", 64'(gnt), 64'h2);
        step();
        req = '0;

        // Carry chain boundaries, back to back from different requesters
        do_reset();
        step();
        req = 4'b0001;
        op1[0*WIDTH +: WIDTH] = 64'h7FFF_FFFF_FFFF_FFFF;
        op2[0*WIDTH +: WIDTH] = 64'h1;
        op1[1*WIDTH +: WIDTH] = 64'h8000_0000_0000_0000;
        op2[1*WIDTH +: WIDTH] = 64'h8000_0000_0000_0000;
        sample();
        chk("cb_gnt_c0", 64'(gnt), 64'h1);
        step();
        req = 4'b0010;
        sample();
        chk("cb_gnt_c1", 64'(gnt), 64'h2);
        step();
        req = '0;
        sample();
        chk("cb_sum_a",  rsp_sum, 64'h8000_0000_0000_0000);
        chk("cb_cout_a", 64'(rsp_cout), 64'h0);
        chk("cb_id_a",   64'(rsp_id), 64'h0);
        step();
        sample();
        chk("cb_sum_b",   rsp_sum, 64'h0);
        chk("cb_cout_b",  64'(rsp_cout), 64'h1);
        chk("cb_id_b",    64'(rsp_id), 64'h1);
        chk("cb_valid_b", 64'(rsp_valid), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/addsub64_rr_arbiter.md
Name: addsub64_rr_arbiter

Overview:
- Shares one 64-bit carry-select add/subtract datapath between NREQ requesters.
- Grants one request per cycle using round-robin arbitration.
- Pipelines the operands and result through two register stages, matching the registered-in/registered-out adder wrapper style.
- Returns each result tagged with the requester ID. Sits between the operand-producing units and the shared 64-bit adder core.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester ID; must equal ceil(log2(NREQ)).
- WIDTH, 64, operand and sum width.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req  input  NREQ  per-requester request
- sub  input  NREQ  per-requester mode: 1 = op1 - op2, 0 = op1 + op2
- op1  input  NREQ*WIDTH  flattened first operands; requester i uses bits [i*WIDTH +: WIDTH]
- op2  input  NREQ*WIDTH  flattened second operands, same packing as op1
- gnt  output  NREQ  one-hot grant; combinational in the request cycle
- busy  output  NREQ  requester has an operation in flight
- rsp_valid  output  1  result valid, single-cycle pulse
- rsp_id  output  IDW  requester ID that owns the result
- rsp_sum  output  WIDTH  result
- rsp_cout  output  1  carry out (for sub: 1 = no borrow)

Behaviour:
- Eligibility: eligible[i] = req[i] & ~busy[i].
- Arbitration:
  - Round-robin pointer ptr (IDW bits). Search order is ptr, ptr+1, ..., wrapping modulo NREQ.
  - The first eligible requester found gets gnt.
  - gnt is all zeros when no requester is eligible.
  - At most one gnt bit is set per cycle.
- Pointer update: on a cycle with a grant to k, ptr <= (k+1) mod NREQ. With no grant, ptr holds.
- Handshake:
  - The request is accepted in the cycle where gnt[i]=1.
  - The requester must hold op1, op2 and sub valid during that cycle only.
  - req may stay high afterwards; it is ignored while busy[i]=1.
- busy:
  - Set at the accept edge.
  - Cleared at the edge where that requester's rsp_valid is deasserted, i.e. after the response cycle.
  - A requester may re-win on the cycle after its response cycle, never during it.
- Stage 1 (accept edge): register the selected operands into a1 and b1.
  - b1 = sub ? ~op2 : op2.
  - Also register cin1 = sub, v1 = 1, and id1 = k.
- Stage 2 (next edge):
  - {rsp_cout, rsp_sum} <= a1 + b1 + cin1, computed by the 64-bit carry-select core (combinational between stages).
  - rsp_valid <= v1; rsp_id <= id1.
- Latency:
  - Grant in cycle N gives rsp_valid high in cycle N+2.
  - Throughput is one operation per cycle across distinct requesters.
- Width rules:
  - Sum wraps modulo 2^64.
  - Carry is reported only on rsp_cout; no overflow flag.
- rsp_valid is deasserted with all other rsp_* outputs holding their last value; rsp_sum and rsp_cout only change when v1 = 1.
- Simultaneous events:
  - All requesters eligible: ptr decides the winner.
  - A response and a new grant in the same cycle (same or different requester) are independent.
  - For the same requester, busy blocks regrant until the cycle after the response.
- Reset (asynchronous, any time, including mid-operation):
  - ptr=0; busy=0; v1=0; a1, b1, cin1, id1 = 0.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0.
  - In-flight operations are discarded and no response is produced for them.
  - gnt=0 while reset is high.
- No response backpressure: consumers must accept rsp_valid whenever it is asserted.

Test Plan:
- Single add: req[0]=1, op1=64'hFFFF_FFFF_FFFF_FFFF, op2=1, sub=0 at cycle 0 -> gnt=4'b0001 at cycle 0; rsp_valid=1 at cycle 2, rsp_id=0, rsp_sum=0, rsp_cout=1; busy[0] high in cycles 1-2.
- Subtract: req[2]=1, sub=1, op1=5, op2=7 -> rsp_sum=64'hFFFF_FFFF_FFFF_FFFE, rsp_cout=0, rsp_id=2. Then op1=7, op2=5 -> sum=2, cout=1.
- Round-robin: req=4'b1111 held, each requester's operands distinct (op1=i, op2=100) -> grants 0,1,2,3 in consecutive cycles. Responses with ids 0,1,2,3 on cycles 2..5, sums 100..103. Requester 0 regranted no earlier than cycle 3.
- Blocking: req[1] held high continuously, others idle -> grants at cycles 0, 3, 6. No grant while busy[1]=1.
- Mid-operation reset: grant req[3] at cycle 0, assert reset during cycle 1 -> rsp_valid never asserted for that op. After release, busy=0, ptr=0, and req=4'b1010 grants requester 1 first.
- Carry chain boundaries: op1=64'h7FFF_FFFF_FFFF_FFFF, op2=1 -> 64'h8000_0000_0000_0000, cout=0. op1=op2=64'h8000_0000_0000_0000 -> sum=0, cout=1.
